// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - two-requester arbiter for the register file write port
// Load wins same-address conflicts; otherwise round-robin. Winner is registered onto the write port.
module rf_write_arbiter #(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Stall,
    input  logic         AluValid,
    input  logic [D-1:0] AluAddr,
    input  logic [W-1:0] AluData,
    output logic         AluReady,
    input  logic         MemValid,
    input  logic [D-1:0] MemAddr,
    input  logic [W-1:0] MemData,
    output logic         MemReady,
    output logic         WriteEn,
    output logic [D-1:0] Waddr,
    output logic [W-1:0] DataIn,
    output logic         LastGrant
);

    logic         write_en_q, write_en_d;
    logic [D-1:0] waddr_q, waddr_d;
    logic [W-1:0] data_in_q, data_in_d;
    logic         last_grant_q, last_grant_d;

    logic both_valid;
    logic same_addr;
    logic alu_win;
    logic mem_win;

    assign both_valid = AluValid && MemValid;
    assign same_addr  = (AluAddr == MemAddr);

    // The load is older in program order, so on a shared destination it must land first.
    always_comb begin
        alu_win = 1'b0;
        mem_win = 1'b0;
        if (!Stall) begin
            if (both_valid) begin
                if (same_addr || !last_grant_q) begin
                    mem_win = 1'b1;
                end else begin
                    alu_win = 1'b1;
                end
            end else begin
                alu_win = AluValid;
                mem_win = MemValid;
            end
        end
    end

    assign AluReady = alu_win;
    assign MemReady = mem_win;

    always_comb begin
        write_en_d   = alu_win || mem_win;
        waddr_d      = waddr_q;
        data_in_d    = data_in_q;
        last_grant_d = last_grant_q;
        if (alu_win) begin
            waddr_d      = AluAddr;
            data_in_d    = AluData;
            last_grant_d = 1'b0;
        end else if (mem_win) begin
            waddr_d      = MemAddr;
            data_in_d    = MemData;
            last_grant_d = 1'b1;
        end
    end

    // LastGrant resets to the load path so the ALU takes the first contended grant.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            write_en_q   <= 1'b0;
            waddr_q      <= '0;
            data_in_q    <= '0;
            last_grant_q <= 1'b1;
        end else begin
            write_en_q   <= write_en_d;
            waddr_q      <= waddr_d;
            data_in_q    <= data_in_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign WriteEn   = write_en_q;
    assign Waddr     = waddr_q;
    assign DataIn    = data_in_q;
    assign LastGrant = last_grant_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Stall;
    logic       AluValid;
    logic [2:0] AluAddr;
    logic [7:0] AluData;
    logic       AluReady;
    logic       MemValid;
    logic [2:0] MemAddr;
    logic [7:0] MemData;
    logic       MemReady;
    logic       WriteEn;
    logic [2:0] Waddr;
    logic [7:0] DataIn;
    logic       LastGrant;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] rf [8];
    logic [7:0] alu_d;
    logic [7:0] mem_d;
    logic       exp_alu;

    rf_write_arbiter #(.W(8), .D(3)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall),
        .AluValid(AluValid), .AluAddr(AluAddr), .AluData(AluData), .AluReady(AluReady),
        .MemValid(MemValid), .MemAddr(MemAddr), .MemData(MemData), .MemReady(MemReady),
        .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn), .LastGrant(LastGrant)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (WriteEn) rf[Waddr] <= DataIn;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_port(input string tag, input logic we, input logic [2:0] a,
                            input logic [7:0] d, input logic lg);
        chk({tag, ".we"}, WriteEn, we);
        chk({tag, ".waddr"}, Waddr, a);
        chk({tag, ".data"}, DataIn, d);
        chk({tag, ".last"}, LastGrant, lg);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 8'h00;
        Reset = 1'b1; Stall = 1'b0;
        AluValid = 1'b0; AluAddr = '0; AluData = '0;
        MemValid = 1'b0; MemAddr = '0; MemData = '0;
        #1;
        chk_port("reset", 1'b0, 3'd0, 8'h00, 1'b1);
        tick();
        tick();
        Reset = 1'b0;

        // single ALU requester
        AluValid = 1'b1; AluAddr = 3'd3; AluData = 8'h5A;
        #1;
        chk("single.alu_ready", AluReady, 1'b1);
        chk("single.mem_ready", MemReady, 1'b0);
        tick();
        chk_port("single", 1'b1, 3'd3, 8'h5A, 1'b0);
        AluValid = 1'b0;
        #1;
        chk("idle.alu_ready", AluReady, 1'b0);
        tick();
        chk("single.rf3", rf[3], 8'h5A);
        chk("single.we_drop", WriteEn, 1'b0);

        // reset mid-stream cancels a pending write
        AluValid = 1'b1; AluAddr = 3'd7; AluData = 8'h77;
        tick();
        AluValid = 1'b0;
        chk("rst.pre_we", WriteEn, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        chk_port("rst_mid", 1'b0, 3'd0, 8'h00, 1'b1);
        tick();
        chk("rst.rf7_cancel", rf[7], 8'h00);
        Reset = 1'b0;

        // contention with different addresses: ALU first, then alternate
        alu_d = 8'h11; mem_d = 8'h22;
        for (int c = 0; c < 4; c++) begin
            AluValid = 1'b1; AluAddr = 3'd1; AluData = alu_d;
            MemValid = 1'b1; MemAddr = 3'd2; MemData = mem_d;
            exp_alu = (c % 2 == 0);
            #1;
            chk("rr.alu_ready", AluReady, exp_alu);
            chk("rr.mem_ready", MemReady, !exp_alu);
            tick();
            chk_port("rr", 1'b1, exp_alu ? 3'd1 : 3'd2, exp_alu ? alu_d : mem_d, !exp_alu);
            if (exp_alu) alu_d = alu_d + 8'h01;
            else mem_d = mem_d + 8'h01;
        end

        // equal address: load wins even though round-robin favours the ALU
        AluAddr = 3'd5; AluData = 8'hBB;
        MemAddr = 3'd5; MemData = 8'hAA;
        #1;
        chk("eq.mem_ready", MemReady, 1'b1);
        chk("eq.alu_ready", AluReady, 1'b0);
        tick();
        chk_port("eq_load", 1'b1, 3'd5, 8'hAA, 1'b1);
        MemValid = 1'b0;
        #1;
        chk("eq.alu_ready2", AluReady, 1'b1);
        tick();
        chk_port("eq_alu", 1'b1, 3'd5, 8'hBB, 1'b0);
        AluValid = 1'b0;
        tick();
        chk("eq.rf5", rf[5], 8'hBB);

        // stall holds off both requesters
        AluValid = 1'b1; AluAddr = 3'd1; AluData = 8'h31;
        MemValid = 1'b1; MemAddr = 3'd2; MemData = 8'h42;
        Stall = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("stall.alu_ready", AluReady, 1'b0);
            chk("stall.mem_ready", MemReady, 1'b0);
            tick();
            chk_port("stall", 1'b0, 3'd5, 8'hBB, 1'b0);
        end
        Stall = 1'b0;
        #1;
        chk("unstall.mem_ready", MemReady, 1'b1);
        tick();
        chk_port("unstall_mem", 1'b1, 3'd2, 8'h42, 1'b1);
        MemValid = 1'b0;
        #1;
        chk("unstall.alu_ready", AluReady, 1'b1);
        tick();
        chk_port("unstall_alu", 1'b1, 3'd1, 8'h31, 1'b0);
        AluValid = 1'b0;

        // idle: outputs hold, WriteEn low
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_port("idle", 1'b0, 3'd1, 8'h31, 1'b0);
        end
        chk("idle.rf2", rf[2], 8'h42);
        chk("idle.rf1", rf[1], 8'h31);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port between two writeback requesters: the ALU result path and the data-memory load path. Each requester uses a valid/ready handshake. The arbiter picks at most one winner per cycle and registers the winning address and data onto the register file's write-enable, write-address and data-in inputs. It sits between the execute/memory stages and the 8-deep, 8-bit register file.

## Interface
Parameters:
- W, 8, data path width; matches the register file data width.
- D, 3, register address width; the register file is 2**D entries deep.

Ports:
- Clk  input  1  the single clock; all state updates on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Stall  input  1  when 1, no grant is issued this cycle.
- AluValid  input  1  ALU requests a write.
- AluAddr  input  D  ALU destination register.
- AluData  input  W  ALU write data.
- AluReady  output  1  ALU request accepted this cycle (combinational).
- MemValid  input  1  load path requests a write.
- MemAddr  input  D  load destination register.
- MemData  input  W  load write data.
- MemReady  output  1  load request accepted this cycle (combinational).
- WriteEn  output  1  registered; drives the register file write enable.
- Waddr  output  D  registered; drives the register file write address.
- DataIn  output  W  registered; drives the register file write data.
- LastGrant  output  1  registered; 0 means the ALU won the most recent grant, 1 means the load path won it.

## Operation
- **Handshake:** a transfer happens on a cycle where Valid=1 and Ready=1. A requester holds Valid, Addr and Data stable until it sees Ready. Ready is never 1 while that requester's Valid is 0.
- **Grant rules** (combinational, evaluated every cycle):
  - Stall=1: no grant; AluReady=0 and MemReady=0.
  - Only one Valid: that requester is granted.
  - Both Valid and AluAddr==MemAddr: the load path wins. The load is older in program order, so the ALU write lands last and its value is the one left in the register.
  - Both Valid with different addresses: round-robin. The requester that did not win the last grant wins now (LastGrant=1 gives the ALU the grant, LastGrant=0 gives the load path the grant).
  - At most one Ready is 1 in any cycle.
- **State update** on each rising clock edge:
  - Grant issued: WriteEn<=1, Waddr/DataIn<=the winner's Addr/Data, LastGrant<=the winner's id.
  - No grant: WriteEn<=0; Waddr, DataIn and LastGrant hold their values.
- **Reset** (asynchronous, takes effect immediately): WriteEn=0, Waddr=0, DataIn=0, LastGrant=1, so the ALU wins the first contended grant.
  - Reset asserted in the cycle after a grant cancels the pending register file write, because WriteEn is cleared before the next edge.
  - A requester accepted before reset is not replayed.
- **Widths:** no arithmetic is performed; Addr and Data pass through unmodified. The block produces no out-of-range address, since Waddr is exactly D bits.

## Timing
- **Grant latency:** Ready is asserted in the same cycle as Valid when the requester wins; there is zero-cycle acceptance.
- **Write latency:** a grant at edge N produces WriteEn=1 with the registered address and data during cycle N..N+1. The register file stores the value at edge N+1, two edges after the request was first presented.
- **Throughput:** one write per cycle sustained. Back-to-back grants produce WriteEn=1 on consecutive cycles with no bubble.
- **Starvation bound:** under continuous contention with different addresses, each requester waits at most 1 cycle.
  - The equal-address rule can hold off the ALU for 1 cycle only. Once the load is accepted its Valid drops, or it carries a new request that is subject to round-robin unless the address matches again.
- **Stall:** takes effect in the same cycle; the WriteEn produced on the following edge is 0.
- **Reset release:** the first grant can occur in the first cycle with Reset=0.

## Test plan
- **Reset:** assert Reset mid-stream with WriteEn=1 -> WriteEn, Waddr and DataIn read 0 immediately; LastGrant=1. After release, the first contended cycle grants the ALU.
- **Single requester:** AluValid=1, AluAddr=3, AluData=0x5A, MemValid=0 -> AluReady=1 the same cycle; next cycle WriteEn=1, Waddr=3, DataIn=0x5A, LastGrant=0. The register file holds reg3=0x5A one edge later.
- **Contention, different addresses:** both Valid held 4 cycles (ALU addr 1, data 0x11; load addr 2, data 0x22; new data each accept) -> grants alternate ALU, load, ALU, load; WriteEn stays 1 for 4 consecutive cycles.
- **Equal-address ordering:** both Valid, addr 5, Mem=0xAA, ALU=0xBB -> the load is granted first, the ALU next cycle; reg5 ends at 0xBB.
- **Stall:** both Valid with Stall=1 for 2 cycles -> both Ready stay 0 and WriteEn=0. After Stall drops, grants resume per LastGrant with no lost request.
- **Idle:** both Valid=0 for 3 cycles after a write -> WriteEn=0; Waddr, DataIn and LastGrant hold their last values.
